multiplexer_n_to_1_reg: RTL and testbench
=========================================

Name: multiplexer_n_to_1_reg

Overview:
Parametrised N-input, NBits-wide multiplexer with a registered output stage and a valid/ready handshake on every input channel and on the output. Two modes:
- Direct: channel chosen by Selector.
- Round-robin: fair arbitration among valid inputs.
Used wherever a datapath mux must be pipelined or shared between producers, such as write-back source select or a memory port shared by fetch and data.

Parameters:
NBits, 32, data width per channel
NInputs, 4, number of input channels (legal 2..16)
SelBits, 2, selector/grant width; must equal $clog2(NInputs)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
Mode  input  1  0 = direct select, 1 = round-robin
Selector  input  SelBits  channel index used in direct mode
Data  input  NInputs*NBits  packed inputs; channel i = Data[i*NBits +: NBits]
InValid  input  NInputs  per-channel data valid
InReady  output  NInputs  per-channel accept (combinational)
OUT  output  NBits  registered output data
OutValid  output  1  OUT holds valid data
OutReady  input  1  consumer accepts OUT this cycle
Grant  output  SelBits  registered index of the channel that produced OUT
RangeErr  output  1  one-cycle pulse: direct-mode Selector >= NInputs

Behaviour:
- Reset (async, active-high): OUT=0, OutValid=0, Grant=0, RangeErr=0, round-robin pointer Last=NInputs-1 (first search starts at channel 0).
- Load enable: load = !OutValid || OutReady. This gives full throughput, 1 transfer per cycle, with no bubbles.
- Latency: an input accepted at edge k appears on OUT/OutValid after edge k (1 cycle).
- Candidate selection (combinational):
  - Direct mode: cand = Selector.
  - Round-robin mode: cand = the first i with InValid[i]=1, searching Last+1, Last+2, … wrapping modulo NInputs. If no input is valid, there is no candidate.
- Transfer: InReady[cand] = load & InValid[cand]. All other InReady bits are 0. On transfer: OUT <= Data[cand], Grant <= cand, OutValid <= 1.
  - In round-robin mode, Last <= cand on transfer only.
  - In direct mode, Last is unchanged.
- No transfer and OutReady=1: OutValid <= 0. OUT and Grant hold their last values.
- No transfer and OutValid=1, OutReady=0: OUT, Grant, OutValid all hold (stall). InReady is all-zero.
- Direct mode, Selector >= NInputs (only when NInputs is not a power of 2):
  - No transfer; all InReady = 0.
  - If load=1: OUT <= 0, OutValid <= 0, RangeErr pulses 1 for one cycle.
  - RangeErr is 0 otherwise.
- Mode may change on any cycle; the new mode applies the same cycle. Last is retained across mode changes.
- Wrap-around: when Last=NInputs-1, the search starts at channel 0.
- Reset asserted mid-transfer: the register clears immediately; the in-flight word is dropped. The producer sees InReady=0 while reset is high.
- Out-of-range direct-mode indices are never stored in Last.

Optional Feature:
Macro MUXN_XFER_COUNT_EN.
- Defined: adds output port XferCount (16 bits). It counts completed input transfers, resets to 0 on reset, and saturates at 16'hFFFF (no wrap).
- Not defined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then Mode=0, Selector=2, InValid=4'b0100, Data ch2=32'hDEADBEEF, OutReady=1 -> next cycle OUT=32'hDEADBEEF, OutValid=1, Grant=2; InReady=4'b0100 in the accept cycle.
- Mode=1, InValid=4'b1111 held, OutReady=1 for 5 cycles after reset -> Grant sequence 0,1,2,3,0, one word per cycle with no bubbles.
- Mode=1, InValid=4'b1010, Last=1 -> grant 3 then 1. Drop InValid[3] after the first grant -> grants continue 1,1,1.
- Output stall: OutValid=1, OutReady=0 for 3 cycles with new Data applied -> OUT/Grant unchanged, InReady=0. Raise OutReady -> the pending candidate loads next cycle.
- NInputs=3, Mode=0, Selector=3, OutReady=1 -> RangeErr=1 for one cycle, OutValid=0, OUT=0, InReady=3'b000.
- With MUXN_XFER_COUNT_EN: preload the counter by forcing 65534 transfers (or via hierarchical force), then 3 more -> XferCount=16'hFFFF and it stays there. Assert reset mid-stream -> XferCount=0, OutValid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/multiplexer_n_to_1_reg.sv
`timescale 1ns/1ps
// multiplexer_n_to_1_reg
//   N-input, NBits-wide mux with a registered output stage and valid/ready
//   handshakes on every input channel and on the output. Mode 0 picks the
//   channel named by Selector; Mode 1 arbitrates round-robin among valid inputs.
//
// Ports
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   Mode           0 = direct select, 1 = round-robin
//   Selector       channel index used in direct mode
//   Data           packed inputs, channel i = Data[i*NBits +: NBits]
//   InValid        per-channel valid
//   InReady        per-channel accept (combinational)
//   OUT, OutValid  registered output word and its valid
//   OutReady       consumer accepts OUT this cycle
//   Grant          registered index of the channel that produced OUT
//   RangeErr       one-cycle pulse: direct-mode Selector >= NInputs
//   XferCount      saturating count of input transfers (only with
//                  MUXN_XFER_COUNT_EN defined)

// Per-channel slice: accept strobe and masked data for the OR-reduce mux.
module mux_lane #(
  parameter int NBits = 32
) (
  input  logic             hit,
  input  logic             valid,
  input  logic             load,
  input  logic [NBits-1:0] din,
  output logic             rdy,
  output logic [NBits-1:0] dout
);
  assign rdy  = hit & valid & load;
  assign dout = hit ? din : '0;
endmodule

module multiplexer_n_to_1_reg #(
  parameter int NBits   = 32,
  parameter int NInputs = 4,
  parameter int SelBits = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     Mode,
  input  logic [SelBits-1:0]       Selector,
  input  logic [NInputs*NBits-1:0] Data,
  input  logic [NInputs-1:0]       InValid,
  output logic [NInputs-1:0]       InReady,
  output logic [NBits-1:0]         OUT,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [SelBits-1:0]       Grant,
  output logic                     RangeErr
`ifdef MUXN_XFER_COUNT_EN
  ,
  output logic [15:0]              XferCount
`endif
);

  logic                           load, in_range, has_cand, xfer, rng_err;
  logic                           rr_hit;
  logic [SelBits-1:0]             last, rr_cand, cand;
  logic [NInputs-1:0][NBits-1:0]  lane_din, lane_dout;
  logic [NBits-1:0]               nxt_data;

  // Holding reset in the load term keeps InReady low while reset is high,
  // so a producer never believes a word was taken during reset.
  assign load     = !reset && (!OutValid || OutReady);
  assign in_range = int'(Selector) < NInputs;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    rr_hit  = 1'b0;
    rr_cand = '0;
    for (int k = 1; k <= NInputs; k++) begin
      int idx;
      idx = int'(last) + k;
      if (idx >= NInputs) idx = idx - NInputs;
      if (!rr_hit && InValid[SelBits'(idx)]) begin
        rr_hit  = 1'b1;
        rr_cand = SelBits'(idx);
      end
    end
  end

  assign cand     = Mode ? rr_cand : Selector;
  assign has_cand = Mode ? rr_hit  : in_range;
  assign rng_err  = !Mode && !in_range && load;

  for (genvar i = 0; i < NInputs; i++) begin : g_lane
    assign lane_din[i] = Data[i*NBits +: NBits];
    mux_lane #(.NBits(NBits)) u_lane (
      .hit   (has_cand && (cand == SelBits'(i))),
      .valid (InValid[i]),
      .load  (load),
      .din   (lane_din[i]),
      .rdy   (InReady[i]),
      .dout  (lane_dout[i])
    );
  end

  // At most one lane is hit, so OR-reducing the masked lanes is the mux.
  always_comb begin
    nxt_data = '0;
    for (int i = 0; i < NInputs; i++) nxt_data = nxt_data | lane_dout[i];
  end

  assign xfer = |InReady;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      OUT      <= '0;
      OutValid <= 1'b0;
      Grant    <= '0;
      RangeErr <= 1'b0;
      last     <= SelBits'(NInputs - 1);
    end else begin
      RangeErr <= rng_err;
      if (xfer) begin
        OUT      <= nxt_data;
        Grant    <= cand;
        OutValid <= 1'b1;
        if (Mode) last <= cand;
      end else if (rng_err) begin
        OUT      <= '0;
        OutValid <= 1'b0;
      end else if (OutReady) begin
        OutValid <= 1'b0;
      end
    end
  end

`ifdef MUXN_XFER_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         XferCount <= '0;
    else if (xfer && XferCount != '1)  XferCount <= XferCount + 16'd1;
  end
`endif

endmodule

// File: tb/tb_multiplexer_n_to_1_reg.sv
`timescale 1ns/1ps
module tb_multiplexer_n_to_1_reg;

  logic         clk = 1'b0;
  logic         reset;
  // 4-input instance
  logic         Mode;
  logic [1:0]   Selector;
  logic [127:0] Data;
  logic [3:0]   InValid, InReady;
  logic [31:0]  OUT;
  logic         OutValid, OutReady, RangeErr;
  logic [1:0]   Grant;
  // 3-input instance (non-power-of-2, exercises out-of-range selector)
  logic         mode3;
  logic [1:0]   sel3;
  logic [95:0]  data3;
  logic [2:0]   inv3, inr3;
  logic [31:0]  out3;
  logic         ov3, ordy3, rerr3;
  logic [1:0]   grant3;
`ifdef MUXN_XFER_COUNT_EN
  logic [15:0]  XferCount, cnt3;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multiplexer_n_to_1_reg #(.NBits(32), .NInputs(4), .SelBits(2)) u_dut (
    .clk(clk), .reset(reset), .Mode(Mode), .Selector(Selector), .Data(Data),
    .InValid(InValid), .InReady(InReady), .OUT(OUT), .OutValid(OutValid),
    .OutReady(OutReady), .Grant(Grant), .RangeErr(RangeErr)
`ifdef MUXN_XFER_COUNT_EN
    , .XferCount(XferCount)
`endif
  );

  multiplexer_n_to_1_reg #(.NBits(32), .NInputs(3), .SelBits(2)) u_dut3 (
    .clk(clk), .reset(reset), .Mode(mode3), .Selector(sel3), .Data(data3),
    .InValid(inv3), .InReady(inr3), .OUT(out3), .OutValid(ov3),
    .OutReady(ordy3), .Grant(grant3), .RangeErr(rerr3)
`ifdef MUXN_XFER_COUNT_EN
    , .XferCount(cnt3)
`endif
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); step(); reset = 1'b0; #1;
  endtask

  task automatic test_reset();
    Mode = 1'b1; Selector = 2'd0; Data = '0; InValid = 4'b1111; OutReady = 1'b1;
    mode3 = 1'b0; sel3 = 2'd0; data3 = '0; inv3 = 3'b000; ordy3 = 1'b1;
    reset = 1'b1; #3;
    n_cmp++; if ({OUT, OutValid, Grant, RangeErr} !== 36'd0) begin
      n_bad++; $display("FAIL reset_state: got out=%h v=%b g=%0d re=%b, want all 0", OUT, OutValid, Grant, RangeErr); end
    n_cmp++; if (InReady !== 4'b0000) begin
      n_bad++; $display("FAIL reset_inready: got %b want 0000", InReady); end
    step(); reset = 1'b0; #1;
  endtask

  task automatic test_direct();
    Mode = 1'b0; Selector = 2'd2; InValid = 4'b0100; OutReady = 1'b1;
    Data = {32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'h00000000};
    #1;
    n_cmp++; if (InReady !== 4'b0100) begin
      n_bad++; $display("FAIL direct_inready: got %b want 0100", InReady); end
    step();
    n_cmp++; if ({OutValid, Grant, OUT} !== {1'b1, 2'd2, 32'hDEADBEEF}) begin
      n_bad++; $display("FAIL direct_out: got v=%b g=%0d d=%h want 1/2/deadbeef", OutValid, Grant, OUT); end
    // selected channel not valid: nothing accepted, output drains, data held
    Selector = 2'd1; #1;
    n_cmp++; if (InReady !== 4'b0000) begin
      n_bad++; $display("FAIL direct_idle_inready: got %b want 0000", InReady); end
    step();
    n_cmp++; if ({OutValid, Grant, OUT} !== {1'b0, 2'd2, 32'hDEADBEEF}) begin
      n_bad++; $display("FAIL direct_drain: got v=%b g=%0d d=%h want 0/2/deadbeef", OutValid, Grant, OUT); end
  endtask

  task automatic test_rr_all();
    logic [31:0] exp_d;
    do_reset();
    Mode = 1'b1; InValid = 4'b1111; OutReady = 1'b1;
    Data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (InReady !== (4'b0001 << (k % 4))) begin
        n_bad++; $display("FAIL rr_all_inready[%0d]: got %b want %b", k, InReady, 4'b0001 << (k % 4)); end
      step();
      exp_d = 32'hA0 + 32'(k % 4);
      n_cmp++; if ({OutValid, Grant, OUT} !== {1'b1, 2'(k % 4), exp_d}) begin
        n_bad++; $display("FAIL rr_all_grant[%0d]: got v=%b g=%0d d=%h want 1/%0d/%h", k, OutValid, Grant, OUT, k % 4, exp_d); end
    end
  endtask

  task automatic test_rr_sparse();
    do_reset();
    Mode = 1'b1; OutReady = 1'b1; InValid = 4'b0010;
    step();   // grant 1, pointer now 1
    n_cmp++; if (Grant !== 2'd1) begin
      n_bad++; $display("FAIL rr_setup: got g=%0d want 1", Grant); end
    InValid = 4'b1010; #1;
    n_cmp++; if (InReady !== 4'b1000) begin
      n_bad++; $display("FAIL rr_sparse_inready: got %b want 1000", InReady); end
    step();
    n_cmp++; if (Grant !== 2'd3) begin
      n_bad++; $display("FAIL rr_sparse_first: got g=%0d want 3", Grant); end
    InValid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if ({OutValid, Grant} !== {1'b1, 2'd1}) begin
        n_bad++; $display("FAIL rr_sparse_repeat[%0d]: got v=%b g=%0d want 1/1", k, OutValid, Grant); end
    end
  endtask

  task automatic test_stall();
    Mode = 1'b0; Selector = 2'd0; InValid = 4'b0001; OutReady = 1'b1;
    Data = {96'd0, 32'h000000A1};
    step();
    n_cmp++; if ({OutValid, Grant, OUT} !== {1'b1, 2'd0, 32'hA1}) begin
      n_bad++; $display("FAIL stall_setup: got v=%b g=%0d d=%h want 1/0/a1", OutValid, Grant, OUT); end
    OutReady = 1'b0; Data = {96'd0, 32'h000000B2};
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (InReady !== 4'b0000) begin
        n_bad++; $display("FAIL stall_inready[%0d]: got %b want 0000", k, InReady); end
      step();
      n_cmp++; if ({OutValid, Grant, OUT} !== {1'b1, 2'd0, 32'hA1}) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got v=%b g=%0d d=%h want 1/0/a1", k, OutValid, Grant, OUT); end
    end
    OutReady = 1'b1; #1;
    n_cmp++; if (InReady !== 4'b0001) begin
      n_bad++; $display("FAIL stall_release_inready: got %b want 0001", InReady); end
    step();
    n_cmp++; if ({OutValid, OUT} !== {1'b1, 32'hB2}) begin
      n_bad++; $display("FAIL stall_release: got v=%b d=%h want 1/b2", OutValid, OUT); end
  endtask

  // Direct-mode transfers must not move the round-robin pointer (still 1).
  task automatic test_mode_switch();
    Mode = 1'b1; InValid = 4'b1111; #1;
    n_cmp++; if (InReady !== 4'b0100) begin
      n_bad++; $display("FAIL mode_switch_inready: got %b want 0100", InReady); end
    step();
    n_cmp++; if (Grant !== 2'd2) begin
      n_bad++; $display("FAIL mode_switch_grant: got g=%0d want 2", Grant); end
  endtask

  task automatic test_reset_mid();
    #2; reset = 1'b1; #1;
    n_cmp++; if ({OutValid, Grant, OUT} !== 35'd0) begin
      n_bad++; $display("FAIL reset_mid: got v=%b g=%0d d=%h want 0/0/0", OutValid, Grant, OUT); end
    n_cmp++; if (InReady !== 4'b0000) begin
      n_bad++; $display("FAIL reset_mid_inready: got %b want 0000", InReady); end
    #1; reset = 1'b0; #1;
  endtask

  task automatic test_range();
    do_reset();
    mode3 = 1'b0; sel3 = 2'd1; inv3 = 3'b111; ordy3 = 1'b1;
    data3 = {32'hC2, 32'hC1, 32'hC0};
    step();
    n_cmp++; if ({ov3, grant3, out3, rerr3} !== {1'b1, 2'd1, 32'hC1, 1'b0}) begin
      n_bad++; $display("FAIL range_setup: got v=%b g=%0d d=%h re=%b want 1/1/c1/0", ov3, grant3, out3, rerr3); end
    sel3 = 2'd3; #1;
    n_cmp++; if (inr3 !== 3'b000) begin
      n_bad++; $display("FAIL range_inready: got %b want 000", inr3); end
    step();
    n_cmp++; if ({rerr3, ov3, out3} !== {1'b1, 1'b0, 32'h0}) begin
      n_bad++; $display("FAIL range_err: got re=%b v=%b d=%h want 1/0/0", rerr3, ov3, out3); end
    // round-robin on 3 channels wraps 2 -> 0; pointer untouched by direct mode
    mode3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if ({rerr3, ov3, grant3, out3} !== {1'b0, 1'b1, 2'(k % 3), 32'hC0 + 32'(k % 3)}) begin
        n_bad++; $display("FAIL range_rr_wrap[%0d]: got re=%b v=%b g=%0d d=%h want 0/1/%0d", k, rerr3, ov3, grant3, out3, k % 3); end
    end
    mode3 = 1'b0; sel3 = 2'd0; inv3 = 3'b000;
  endtask

`ifdef MUXN_XFER_COUNT_EN
  task automatic test_xfer_count();
    do_reset();
    Mode = 1'b1; InValid = 4'b1111; OutReady = 1'b1;
    repeat (3) step();
    n_cmp++; if (XferCount !== 16'd3) begin
      n_bad++; $display("FAIL count_small: got %0d want 3", XferCount); end
    repeat (65535) step();
    n_cmp++; if (XferCount !== 16'hFFFF) begin
      n_bad++; $display("FAIL count_sat: got %h want ffff", XferCount); end
    repeat (3) step();
    n_cmp++; if (XferCount !== 16'hFFFF) begin
      n_bad++; $display("FAIL count_hold: got %h want ffff", XferCount); end
    #2; reset = 1'b1; #1;
    n_cmp++; if ({XferCount, OutValid} !== 17'd0) begin
      n_bad++; $display("FAIL count_reset: got c=%h v=%b want 0/0", XferCount, OutValid); end
    #1; reset = 1'b0; #1;
  endtask
`endif

  initial begin
    test_reset();
    test_direct();
    test_rr_all();
    test_rr_sparse();
    test_stall();
    test_mode_switch();
    test_reset_mid();
    test_range();
`ifdef MUXN_XFER_COUNT_EN
    test_xfer_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
